nibble_add_seq: RTL



---
 rtl/nibble_add_pkg.sv | 17 +
 rtl/nibble_add_seq_if.sv | 30 +++
 rtl/skip_adder4.sv | 28 ++
 rtl/nibble_add_seq.sv | 105 ++++++++++
 4 files changed

// File: rtl/nibble_add_pkg.sv
// Shared types and constants for the nibble-serial adder.
package nibble_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIB_W = 4;

    // Width of a nibble index; never narrower than one bit.
    function automatic int idx_width(input int nib);
        return (nib <= 1) ? 1 : $clog2(nib);
    endfunction

endpackage

// File: rtl/nibble_add_seq_if.sv
// Operand/result handshake bundle for nibble_add_seq.
interface nibble_add_seq_if #(
    parameter int WIDTH = 16
);
    localparam int NIB = WIDTH / 4;
    localparam int SKW = $clog2(NIB + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic [SKW-1:0]   skips;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, skips
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf, skips
    );

endinterface

// File: rtl/skip_adder4.sv
// 4-bit ripple adder with a group-propagate carry-skip mux.
module skip_adder4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout,
    output logic       bp
);
    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    always_comb begin
        p    = a ^ b;
        g    = a & b;
        c    = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < 4; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        sum  = p ^ c[3:0];
        bp   = &p;
        // When every bit propagates the carry-in bypasses the ripple chain.
        cout = bp ? cin : c[4];
    end

endmodule

// File: rtl/nibble_add_seq.sv
// Multi-cycle WIDTH-bit adder processing one nibble per clock, LSB first,
// through a single shared skip_adder4 slice.
module nibble_add_seq
    import nibble_add_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    nibble_add_seq_if.slave bus,
    output logic            busy
);
    localparam int NIB = WIDTH / NIB_W;
    localparam int IW  = idx_width(NIB);
    localparam int SKW = $clog2(NIB + 1);
    localparam int MSB = WIDTH - 1;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_r;
    logic             carry;
    logic             cout_r;
    logic             ovf_r;
    logic [IW-1:0]    idx;
    logic [SKW-1:0]   skips_r;

    logic [3:0]       s_a;
    logic [3:0]       s_b;
    logic [3:0]       s_sum;
    logic             s_cout;
    logic             s_bp;
    logic             last;

    always_comb begin
        s_a  = a_reg[idx*NIB_W +: NIB_W];
        s_b  = b_reg[idx*NIB_W +: NIB_W];
        last = (idx == IW'(NIB - 1));
    end

    skip_adder4 u_slice (
        .a    (s_a),
        .b    (s_b),
        .cin  (carry),
        .sum  (s_sum),
        .cout (s_cout),
        .bp   (s_bp)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_reg   <= '0;
            b_reg   <= '0;
            sum_r   <= '0;
            carry   <= 1'b0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
            idx     <= '0;
            skips_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg   <= bus.a;
                        b_reg   <= bus.b;
                        carry   <= bus.cin;
                        idx     <= '0;
                        sum_r   <= '0;
                        skips_r <= '0;
                        ovf_r   <= 1'b0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    sum_r[idx*NIB_W +: NIB_W] <= s_sum;
                    carry   <= s_cout;
                    skips_r <= skips_r + SKW'(s_bp);
                    idx     <= idx + IW'(1);
                    if (last) begin
                        // The slice output is the top nibble here, so s_sum[3] is the new MSB.
                        cout_r <= s_cout;
                        ovf_r  <= (a_reg[MSB] == b_reg[MSB]) && (s_sum[3] != a_reg[MSB]);
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.sum       = sum_r;
    assign bus.cout      = cout_r;
    assign bus.ovf       = ovf_r;
    assign bus.skips     = skips_r;
    assign busy          = (state != IDLE);

endmodule
